// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, R-type funct codes, ALU operation codes and
// the multi-cycle sequencer state enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_EXC = 3'd5
  } state_t;

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// Combinational decode of the latched op/funct into ALU controls and an
// illegal-instruction flag.
module alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [4:0] aluctr,
  output logic       alu_src,
  output logic       ext_op,
  output logic       illegal
);

  always_comb begin
    aluctr  = ALU_ADD;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  aluctr = ALU_ADD;
          FN_SUB:  aluctr = ALU_SUB;
          FN_AND:  aluctr = ALU_AND;
          FN_OR:   aluctr = ALU_OR;
          FN_SLT:  aluctr = ALU_SLT;
          FN_SLL:  aluctr = ALU_SLL;
          FN_SRL:  aluctr = ALU_SRL;
          default: illegal = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
      end
      OP_BEQ: begin
        aluctr = ALU_SUB;
        ext_op = 1'b1;
      end
      OP_J: begin
        aluctr = ALU_ADD;
      end
      OP_ORI: begin
        aluctr  = ALU_OR;
        alu_src = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer (IF/ID/EX/MEM/WB) with a MEM-stage ack stall.
// Define OVF_TRAP_EN to add the EXC state for overflow and illegal instructions.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       ovf,
  input  logic       mem_ack,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       branch,
  output logic       jump,
  output logic       reg_dst,
  output logic       reg_wr,
  output logic       mem_req,
  output logic       mem_wr,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       ext_op,
  output logic [4:0] aluctr,
  output logic [2:0] state,
  output logic       exc
);

  state_t     st;
  logic       run;
  logic [5:0] op_q;
  logic [5:0] funct_q;
  logic [4:0] dec_alu;
  logic       dec_src;
  logic       dec_ext;
  logic       dec_ill;

  alu_decode u_alu_decode (
    .op      (op_q),
    .funct   (funct_q),
    .aluctr  (dec_alu),
    .alu_src (dec_src),
    .ext_op  (dec_ext),
    .illegal (dec_ill)
  );

  logic is_r, is_lw, is_sw, is_beq, is_j;
  assign is_r   = (op_q == OP_RTYPE);
  assign is_lw  = (op_q == OP_LW);
  assign is_sw  = (op_q == OP_SW);
  assign is_beq = (op_q == OP_BEQ);
  assign is_j   = (op_q == OP_J);

`ifdef OVF_TRAP_EN
  localparam state_t ILL_NEXT = S_EXC;
  logic ovf_chk;
  assign ovf_chk = (op_q == OP_ADDI) ||
                   (is_r && (funct_q == FN_ADD || funct_q == FN_SUB));
`else
  localparam state_t ILL_NEXT = S_IF;
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

  // run holds outputs low until the first edge after reset release, so that
  // edge opens the first real IF cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= S_IF;
      run     <= 1'b0;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      case (st)
        S_IF: begin
          op_q    <= op;
          funct_q <= funct;
          st      <= S_ID;
        end
        S_ID: begin
          if (is_j)         st <= S_IF;
          else if (dec_ill) st <= ILL_NEXT;
          else              st <= S_EX;
        end
        S_EX: begin
          if (is_beq)              st <= S_IF;
          else if (is_lw || is_sw) st <= S_MEM;
          else                     st <= S_WB;
`ifdef OVF_TRAP_EN
          if (ovf && ovf_chk) st <= S_EXC;
`endif
        end
        S_MEM: begin
          if (mem_ack) st <= is_sw ? S_IF : S_WB;
        end
        default: st <= S_IF;
      endcase
    end
  end

  assign state = st;

  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    reg_dst    = 1'b0;
    reg_wr     = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    aluctr     = ALU_ADD;
    exc        = 1'b0;
    if (run) begin
      case (st)
        S_IF: begin
          pc_wr = 1'b1;
          ir_wr = 1'b1;
        end
        S_ID: begin
          pc_wr = is_j;
          jump  = is_j;
        end
        S_EX: begin
          aluctr  = dec_alu;
          alu_src = dec_src;
          ext_op  = dec_ext;
          branch  = is_beq;
          pc_wr   = is_beq & zero;
        end
        S_MEM: begin
          aluctr  = dec_alu;
          alu_src = dec_src;
          ext_op  = dec_ext;
          mem_req = 1'b1;
          mem_wr  = is_sw;
        end
        S_WB: begin
          aluctr     = dec_alu;
          alu_src    = dec_src;
          ext_op     = dec_ext;
          reg_wr     = 1'b1;
          reg_dst    = is_r;
          mem_to_reg = is_lw;
        end
`ifdef OVF_TRAP_EN
        S_EXC: exc = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
